io_access_sequencer: RTL and testbench

//   Multi-cycle sequencer for memory-mapped I/O accesses decoded by control32.

---
 rtl/io_access_sequencer.sv | 150 +++++++++++++++
 tb/tb_io_access_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/io_access_sequencer.sv
// Multi-cycle sequencer for memory-mapped LED/switch accesses: stalls the CPU, drives
// chip-select and a one-cycle strobe, waits for device ready with timeout, flags bus errors.
module io_access_sequencer #(
    parameter logic [3:0] LED_OFS = 4'h6,
    parameter logic [3:0] SW_OFS  = 4'h7,
    parameter int         TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_read,
    input  logic        io_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [15:0] dev_rdata,
    input  logic        dev_ready,
    output logic        ledcs,
    output logic        switchcs,
    output logic        ior,
    output logic        iow,
    output logic [1:0]  io_addr,
    output logic [15:0] io_wdata,
    output logic        cpu_stall,
    output logic [31:0] rdata_out,
    output logic        rdata_valid,
    output logic        bus_err,
    output logic [31:0] err_addr
);

    localparam int             CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_addr;
    logic          r_rd;
    logic          r_led;
    logic          w_req;
    logic          w_valid;
    logic          w_cs_act;
    logic          w_stall;
    logic          w_unused_bits;

    assign w_req   = io_read | io_write;
    assign w_valid = (addr[31:10] == 22'h3FFFFF)
                   && ((addr[7:4] == LED_OFS) || (addr[7:4] == SW_OFS))
                   && !(io_read && io_write);
    assign w_unused_bits = ^{addr[9:8], addr[3:2], wdata[31:16]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_cs_act    = 1'b0;
        w_stall     = 1'b0;
        ior         = 1'b0;
        iow         = 1'b0;
        rdata_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_stall = 1'b1;
                    w_next  = w_valid ? S_SETUP : S_ERR;
                end
            end
            S_SETUP: begin
                w_cs_act = 1'b1;
                w_stall  = 1'b1;
                ior      = r_rd;
                iow      = ~r_rd;
                w_next   = S_WAIT;
            end
            S_WAIT: begin
                w_cs_act = 1'b1;
                w_stall  = 1'b1;
                if (dev_ready) begin
                    w_next = S_DONE;
                end else if (r_cnt == LAST) begin
                    w_next = S_ERR;
                end
            end
            // Requests still visible here belong to the finishing instruction.
            S_DONE: begin
                rdata_valid = r_rd;
                w_next      = S_IDLE;
            end
            S_ERR: begin
                rdata_valid = r_rd;
                w_next      = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Stall is gated so it drops the instant reset asserts, even with a request pending.
    assign cpu_stall = w_stall & ~reset;
    assign ledcs     = w_cs_act & r_led;
    assign switchcs  = w_cs_act & ~r_led;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_addr    <= '0;
            r_rd      <= 1'b0;
            r_led     <= 1'b0;
            io_addr   <= '0;
            io_wdata  <= '0;
            rdata_out <= '0;
            bus_err   <= 1'b0;
            err_addr  <= '0;
        end else begin
            if (r_state == S_IDLE && w_req) begin
                r_addr   <= addr;
                r_rd     <= io_read;
                r_led    <= (addr[7:4] == LED_OFS);
                io_addr  <= addr[1:0];
                io_wdata <= wdata[15:0];
            end
            if (r_state == S_SETUP) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT && !dev_ready) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == S_WAIT && dev_ready && r_rd) begin
                rdata_out <= {16'h0000, dev_rdata};
            end
            // Error results are registered on entry so they are visible during ERR.
            if (w_next == S_ERR) begin
                bus_err   <= 1'b1;
                err_addr  <= (r_state == S_IDLE) ? addr : r_addr;
                rdata_out <= '0;
            end
        end
    end

endmodule

// File: tb/tb_io_access_sequencer.sv
// Directed bench for io_access_sequencer with immediate-assertion checks.
module tb_io_access_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_read;
    logic        io_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [15:0] dev_rdata;
    logic        dev_ready;
    logic        ledcs;
    logic        switchcs;
    logic        ior;
    logic        iow;
    logic [1:0]  io_addr;
    logic [15:0] io_wdata;
    logic        cpu_stall;
    logic [31:0] rdata_out;
    logic        rdata_valid;
    logic        bus_err;
    logic [31:0] err_addr;

    int total = 0;
    int bad   = 0;

    // Control vector bits: {ledcs, switchcs, ior, iow, cpu_stall, rdata_valid}
    localparam logic [5:0] L  = 6'b100000;
    localparam logic [5:0] S  = 6'b010000;
    localparam logic [5:0] R  = 6'b001000;
    localparam logic [5:0] W  = 6'b000100;
    localparam logic [5:0] ST = 6'b000010;
    localparam logic [5:0] V  = 6'b000001;

    io_access_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .io_read     (io_read),
        .io_write    (io_write),
        .addr        (addr),
        .wdata       (wdata),
        .dev_rdata   (dev_rdata),
        .dev_ready   (dev_ready),
        .ledcs       (ledcs),
        .switchcs    (switchcs),
        .ior         (ior),
        .iow         (iow),
        .io_addr     (io_addr),
        .io_wdata    (io_wdata),
        .cpu_stall   (cpu_stall),
        .rdata_out   (rdata_out),
        .rdata_valid (rdata_valid),
        .bus_err     (bus_err),
        .err_addr    (err_addr)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ctl(input string tag, input logic [5:0] exp);
        logic [5:0] obs;
        obs = {ledcs, switchcs, ior, iow, cpu_stall, rdata_valid};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s ctl observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        ctl({tag, "_ctl"}, 6'b0);
        chk({tag, "_rdata"}, rdata_out, 32'h0);
        chk({tag, "_buserr"}, {31'h0, bus_err}, 32'h0);
        chk({tag, "_erraddr"}, err_addr, 32'h0);
        chk({tag, "_ioaddr_wdata"}, {14'h0, io_addr, io_wdata}, 32'h0);
    endtask

    initial begin
        reset = 1'b1; io_read = 1'b0; io_write = 1'b0;
        addr = 32'h0; wdata = 32'h0; dev_rdata = 16'h0; dev_ready = 1'b0;
        #2;
        chk_all_zero("reset");
        step(); step();
        reset = 1'b0;

        // LW switch, device ready immediately (ready held high also outside WAIT)
        io_read = 1'b1; addr = 32'hFFFFFC70; dev_rdata = 16'hA5A5; dev_ready = 1'b1;
        #1 ctl("t1_c0", ST); step();
        #1 ctl("t1_c1", S | R | ST); step();
        #1 ctl("t1_c2", S | ST); step();
        #1 ctl("t1_c3_done", V);
        chk("t1_rdata", rdata_out, 32'h0000A5A5); step();
        io_read = 1'b0; dev_ready = 1'b0;
        #1 ctl("t1_idle", 6'b0);
        chk("t1_rdata_hold", rdata_out, 32'h0000A5A5); step();

        // SW LED, ready on the third WAIT cycle
        io_write = 1'b1; addr = 32'hFFFFFC60; wdata = 32'h12345678;
        #1 ctl("t2_c0", ST); step();
        #1 ctl("t2_c1", L | W | ST);
        chk("t2_wdata", {16'h0, io_wdata}, 32'h00005678); step();
        #1 ctl("t2_c2", L | ST); step();
        #1 ctl("t2_c3", L | ST); step();
        dev_ready = 1'b1;
        #1 ctl("t2_c4", L | ST); step();
        #1 ctl("t2_c5_done", 6'b0);
        chk("t2_buserr", {31'h0, bus_err}, 32'h0);
        chk("t2_wdata_done", {16'h0, io_wdata}, 32'h00005678);
        chk("t2_rdata_hold", rdata_out, 32'h0000A5A5); step();
        io_write = 1'b0; dev_ready = 1'b0;
        #1 step();

        // LW switch, device never ready -> timeout
        io_read = 1'b1; addr = 32'hFFFFFC70; dev_rdata = 16'h1111;
        #1 ctl("t3_c0", ST); step();
        #1 ctl("t3_c1", S | R | ST); step();
        for (int i = 0; i < 15; i++) begin
            #1 ctl($sformatf("t3_wait%0d", i), S | ST);
            step();
        end
        #1 ctl("t3_err", V);
        chk("t3_buserr", {31'h0, bus_err}, 32'h1);
        chk("t3_rdata", rdata_out, 32'h0);
        chk("t3_erraddr", err_addr, 32'hFFFFFC70); step();
        io_read = 1'b0;
        #1 ctl("t3_idle", 6'b0); step();

        // Unmapped offset
        io_read = 1'b1; addr = 32'hFFFFFC50;
        #1 ctl("t4a_c0", ST); step();
        #1 ctl("t4a_err", V);
        chk("t4a_erraddr", err_addr, 32'hFFFFFC50); step();
        io_read = 1'b0;
        #1 step();

        // Outside the I/O window
        io_read = 1'b1; addr = 32'h00001070;
        #1 ctl("t4b_c0", ST); step();
        #1 ctl("t4b_err", V);
        chk("t4b_erraddr", err_addr, 32'h00001070); step();
        io_read = 1'b0;
        #1 step();

        // Simultaneous read and write
        io_read = 1'b1; io_write = 1'b1; addr = 32'hFFFFFC70;
        #1 ctl("t4c_c0", ST); step();
        #1 chk("t4c_err_nostrobe", {28'h0, ledcs, switchcs, ior, iow}, 32'h0);
        chk("t4c_stall", {31'h0, cpu_stall}, 32'h0);
        chk("t4c_erraddr", err_addr, 32'hFFFFFC70); step();
        io_read = 1'b0; io_write = 1'b0;
        #1 step();

        // Reset asserted mid-WAIT, then a clean access
        io_read = 1'b1; addr = 32'hFFFFFC70; dev_ready = 1'b0;
        #1 ctl("t5_c0", ST); step();
        #1 ctl("t5_c1", S | R | ST); step();
        #1 ctl("t5_c2", S | ST);
        reset = 1'b1;
        #1 chk_all_zero("t5_rst");
        step();
        reset = 1'b0; dev_rdata = 16'h3C3C; dev_ready = 1'b1;
        #1 ctl("t5_r0", ST); step();
        #1 ctl("t5_r1", S | R | ST); step();
        #1 ctl("t5_r2", S | ST); step();
        #1 ctl("t5_r3_done", V);
        chk("t5_rdata", rdata_out, 32'h00003C3C);
        chk("t5_buserr", {31'h0, bus_err}, 32'h0); step();
        io_read = 1'b0;
        #1 step();

        // Back-to-back SW then LW with requests held through DONE
        io_write = 1'b1; addr = 32'hFFFFFC63; wdata = 32'h0000BEEF; dev_ready = 1'b1;
        #1 ctl("t6_w0", ST); step();
        #1 ctl("t6_w1", L | W | ST);
        chk("t6_ioaddr", {30'h0, io_addr}, 32'h3); step();
        #1 ctl("t6_w2", L | ST); step();
        #1 ctl("t6_w3_done", 6'b0); step();
        io_write = 1'b0; io_read = 1'b1; addr = 32'hFFFFFC72; dev_rdata = 16'h1234;
        #1 ctl("t6_r0", ST); step();
        #1 ctl("t6_r1", S | R | ST);
        chk("t6_ioaddr_rd", {30'h0, io_addr}, 32'h2); step();
        #1 ctl("t6_r2", S | ST); step();
        #1 ctl("t6_r3_done", V);
        chk("t6_rdata", rdata_out, 32'h00001234); step();
        io_read = 1'b0; dev_ready = 1'b0;
        #1 ctl("t6_idle", 6'b0);
        chk("t6_buserr", {31'h0, bus_err}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
